// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Groups the requester handshake and the FIFO write-port signals of the
// arbiter. The clock and reset stay as plain ports on the arbiter.
//   i_req            per-requester "word available" level
//   i_data           requester k data on [k*WORD_SIZE +: WORD_SIZE]
//   o_ack            one-hot pulse, word of requester k consumed this cycle
//   o_grant          one-hot current owner, zero when idle
//   o_fifo_we        FIFO write enable
//   o_fifo_data      FIFO write data
//   i_fifo_not_full  FIFO not-full flag
//   o_busy           high while a burst is in progress
// master: the arbiter side. slave: the requesters/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WORD_SIZE = 8
);
    logic [NUM_REQ-1:0]           i_req;
    logic [NUM_REQ*WORD_SIZE-1:0] i_data;
    logic [NUM_REQ-1:0]           o_ack;
    logic [NUM_REQ-1:0]           o_grant;
    logic                         o_fifo_we;
    logic [WORD_SIZE-1:0]         o_fifo_data;
    logic                         i_fifo_not_full;
    logic                         o_busy;

    modport master (
        input  i_req, i_data, i_fifo_not_full,
        output o_ack, o_grant, o_fifo_we, o_fifo_data, o_busy
    );

    modport slave (
        output i_req, i_data, i_fifo_not_full,
        input  o_ack, o_grant, o_fifo_we, o_fifo_data, o_busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that lets one of NUM_REQ requesters write a burst of up
// to MAX_BURST words into a shared FIFO write port.
// Ports:
//   i_clk    single clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      fifo_wr_arbiter_if master modport (requests, data, acks,
//            grant, FIFO write port, busy)
//
// state | meaning
// IDLE  | no owner; arbitrate among asserted requests this cycle
// BURST | owner holds the FIFO port; one word written per ready cycle
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WORD_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fifo_wr_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   owner_oh;
    logic                 owner_req;
    logic [WORD_SIZE-1:0] owner_data;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 busy;
    logic                 wr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner decode and data mux.
    always_comb begin
        owner_oh   = '0;
        owner_req  = 1'b0;
        owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_oh[k] = 1'b1;
                owner_req   = bus.i_req[k];
                owner_data  = bus.i_data[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Round-robin pick: scan from last_q+1 with wrap. Distances are walked
    // from far to near so the nearest asserted requester is written last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int d = NUM_REQ; d >= 1; d--) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (k == (int'(last_q) + d) % NUM_REQ && bus.i_req[k]) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(k);
                end
            end
        end
    end

    assign busy = (state_q == BURST);
    // Reset gates the write so an aborted burst consumes nothing that cycle.
    assign wr   = busy && owner_req && bus.i_fifo_not_full && !i_reset;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (bus.i_fifo_not_full) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy      = busy;
    assign bus.o_grant     = busy ? owner_oh : '0;
    assign bus.o_ack       = wr ? owner_oh : '0;
    assign bus.o_fifo_we   = wr;
    assign bus.o_fifo_data = busy ? owner_data : '0;
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter WORD_SIZE, default 8, data word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, max words accepted per grant (1..16).
REQ-004 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req  input  NUM_REQ  per-requester "word available" level.
REQ-007 SHALL have port i_data  input  NUM_REQ*WORD_SIZE  requester k data on bits [k*WORD_SIZE +: WORD_SIZE].
REQ-008 SHALL have port o_ack  output  NUM_REQ  one-hot pulse, word of requester k consumed this cycle.
REQ-009 SHALL have port o_grant  output  NUM_REQ  one-hot registered current owner, all-zero when idle.
REQ-010 SHALL have port o_fifo_we  output  1  write enable to FIFO write port.
REQ-011 SHALL have port o_fifo_data  output  WORD_SIZE  write data to FIFO.
REQ-012 SHALL have port i_fifo_not_full  input  1  FIFO not-full flag.
REQ-013 SHALL have port o_busy  output  1  high while in BURST state.

Function
REQ-014 SHALL implement FSM with states IDLE and BURST, plus registers owner index, last-winner index, burst counter (clog2(MAX_BURST)+1 bits).
REQ-015 IDLE: if any i_req bit set, SHALL pick the first set bit scanning round-robin from (last_winner+1) mod NUM_REQ upward with wrap, register it as owner and last_winner, clear burst counter, go BURST next cycle.
REQ-016 IDLE with i_req all zero SHALL stay IDLE; o_grant, o_ack, o_fifo_we all zero.
REQ-017 BURST: o_grant SHALL be one-hot of owner; o_fifo_data SHALL equal owner's data slice (combinational mux).
REQ-018 BURST: o_fifo_we and o_ack[owner] SHALL be asserted combinationally in the same cycle iff i_req[owner] && i_fifo_not_full.
REQ-019 Each write SHALL increment burst counter; a write with counter == MAX_BURST-1 SHALL end the burst (IDLE next cycle).
REQ-020 i_fifo_not_full low in BURST SHALL stall: no write, no ack, counter held, state held (no timeout).
REQ-021 i_req[owner] low in BURST SHALL end the burst that cycle with no write; IDLE next cycle.
REQ-022 Non-owner i_req changes during BURST SHALL be ignored; no o_ack to non-owners ever.
REQ-023 Latency: request seen in IDLE cycle N -> o_grant at N+1 -> earliest write at N+1; exactly one IDLE bubble cycle between consecutive bursts.
REQ-024 Owner SHALL not be re-granted while any other requester is asserted at the arbitration cycle (fairness); sole requester SHALL be re-granted after the bubble.
REQ-025 o_fifo_we SHALL never assert when i_fifo_not_full is low.

Reset
REQ-026 i_reset high SHALL force IDLE, burst counter 0, owner 0, last_winner NUM_REQ-1 (requester 0 wins first), from the next edge.
REQ-027 Outputs after reset: o_grant 0, o_ack 0, o_fifo_we 0, o_busy 0, o_fifo_data 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no write in the reset cycle; words not acked are not consumed.

Verification (NUM_REQ=4, WORD_SIZE=8, MAX_BURST=4)
REQ-029 Reset, then i_req=4'b0001 held, data0=8'hA0, not_full=1 -> grant 0001 next cycle, 4 writes of A0 on consecutive cycles, 1 IDLE cycle, regrant 0001.
REQ-030 i_req=4'b1111 held, not_full=1 -> grant order 0,1,2,3,0, each 4 writes, one bubble between bursts, o_fifo_data matches owner slice.
REQ-031 Owner 2 granted, not_full dropped after 2 writes for 3 cycles -> o_fifo_we/o_ack 0 for 3 cycles, burst resumes, total 4 writes, then IDLE.
REQ-032 Owner 1 granted, i_req[1] drops after 1 write while i_req[3]=1 -> burst ends that cycle, IDLE 1 cycle, grant 1000.
REQ-033 i_reset pulsed during second write of a burst -> no write in reset cycle, outputs 0 next cycle, next grant goes to lowest set requester from index 0.
REQ-034 Scoreboard over all tests: every o_fifo_we cycle has i_fifo_not_full=1 and exactly one o_ack bit equal to o_grant.
